instr_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the control/decode block.
- Holds the program store and the program counter, and issues one 16-bit instruction at a time over a valid/ready handshake.
- Resolves jumps (opcode 15) locally.
- Stalls on BNE (opcode 14) until downstream reports the branch outcome, then redirects the PC.
- Replaces free-running instruction sequencing with a resettable, stall-aware fetch.

---
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Stall-aware fetch stage: program store, pc, local jumps, BNE wait/redirect.
// Define FETCH_PERF_EN to add saturating issue/bubble/taken-branch counters.
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    prog_len,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_valid,
  input  logic               br_taken,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        issued_cnt,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        branch_taken_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    BR_WAIT,
    HALT
  } state_t;

  localparam logic [PC_W-1:0] ONE = 1;

  state_t state, state_n;
  logic [PC_W-1:0]    pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               valid_n;
  logic               halted_n;

  logic [INSTR_W-1:0] mem [2**PC_W];
  logic [INSTR_W-1:0] cur;
  logic [15:0]        jmp_off;
  logic [15:0]        br_off;
  logic               slot_free;
  logic               idle_like;
  logic               is_end;
  logic               is_jmp;
  logic               is_bne;
  logic               br_ok;

  assign cur       = mem[pc];
  assign jmp_off   = {{4{cur[15]}}, cur[15:4]};
  assign br_off    = {{12{instruction[15]}}, instruction[15:12]};
  assign slot_free = !instr_valid || instr_ready;
  assign idle_like = (state == IDLE) || (state == HALT);
  assign is_end    = pc >= prog_len;
  assign is_jmp    = !is_end && (cur[3:0] == 4'hF);
  assign is_bne    = !is_end && (cur[3:0] == 4'hE);
  // Outcome only counts once the branch itself has left the slot
  assign br_ok     = (state == BR_WAIT) && br_valid && slot_free;

  always_ff @(posedge clock) begin
    if (prog_we && idle_like)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instr_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instruction;
    valid_n  = instr_valid;
    halted_n = halted;
    unique case (state)
      IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (slot_free) begin
          unique case (1'b1)
            is_end: begin
              valid_n  = 1'b0;
              halted_n = 1'b1;
              state_n  = HALT;
            end
            is_jmp: begin
              pc_n    = pc + jmp_off[PC_W-1:0];
              valid_n = 1'b0;
            end
            is_bne: begin
              instr_n = cur;
              valid_n = 1'b1;
              state_n = BR_WAIT;
            end
            default: begin
              instr_n = cur;
              valid_n = 1'b1;
              pc_n    = pc + ONE;
            end
          endcase
        end
      end
      BR_WAIT: begin
        if (instr_ready)
          valid_n = 1'b0;
        if (br_ok) begin
          pc_n    = br_taken ? pc + br_off[PC_W-1:0] : pc + ONE;
          state_n = FETCH;
        end
      end
      HALT: begin
        valid_n  = 1'b0;
        halted_n = 1'b1;
        if (start) begin
          halted_n = 1'b0;
          pc_n     = '0;
          state_n  = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic clr;
  logic busy;
  assign clr  = start && idle_like;
  assign busy = (state == FETCH) || (state == BR_WAIT);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      issued_cnt       <= '0;
      bubble_cnt       <= '0;
      branch_taken_cnt <= '0;
    end else begin
      if (instr_valid && instr_ready && issued_cnt != 16'hFFFF)
        issued_cnt <= issued_cnt + 16'd1;
      if (busy && !instr_valid && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
      if (br_ok && br_taken && branch_taken_cnt != 16'hFFFF)
        branch_taken_cnt <= branch_taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an issue-order scoreboard.
// Expected instruction stream is queued at stimulus time, popped on acceptance.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  prog_len;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_valid;
  logic        br_taken;
  logic [7:0]  pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] issued_cnt;
  logic [15:0] bubble_cnt;
  logic [15:0] branch_taken_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];

  instr_fetch_unit dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .prog_len(prog_len),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .br_valid(br_valid),
    .br_taken(br_taken),
    .pc(pc),
    .halted(halted)
`ifdef FETCH_PERF_EN
    ,
    .issued_cnt(issued_cnt),
    .bubble_cnt(bubble_cnt),
    .branch_taken_cnt(branch_taken_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepted instructions must match the queued stream in order
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0)
        chk("sb_extra", {16'h0, instruction}, 32'hFFFF_FFFF);
      else
        chk("sb_order", {16'h0, instruction}, {16'h0, sb.pop_front()});
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic load(logic [7:0] a, logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    cyc(1);
    prog_we   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(string tag);
    for (int i = 0; i < 60; i++) begin
      if (halted) break;
      cyc(1);
    end
    chk(tag, {31'h0, halted}, 32'h1);
  endtask

  task automatic wait_br(logic [15:0] w);
    for (int i = 0; i < 40; i++) begin
      if (instr_valid && instruction === w) break;
      cyc(1);
    end
    chk("br_seen", {31'h0, instr_valid && instruction === w}, 32'h1);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    prog_len    = '0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    instr_ready = 1'b1;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc", {24'h0, pc}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);

    // Sequential issue
    load(8'd0, 16'h1231);
    load(8'd1, 16'h2342);
    load(8'd2, 16'h3453);
    prog_len = 8'd3;
    sb.push_back(16'h1231);
    sb.push_back(16'h2342);
    sb.push_back(16'h3453);
    go();
    chk("seq_c0_valid", {31'h0, instr_valid}, 32'h0);
    cyc(1);
    chk("seq_c1", {15'h0, instr_valid, instruction}, 32'h1_1231);
    cyc(1);
    chk("seq_c2", {15'h0, instr_valid, instruction}, 32'h1_2342);
    cyc(1);
    chk("seq_c3", {15'h0, instr_valid, instruction}, 32'h1_3453);
    cyc(1);
    chk("seq_halt", {31'h0, halted}, 32'h1);
    chk("seq_pc", {24'h0, pc}, 32'd3);
    chk("seq_sb", sb.size(), 32'd0);

    // Jump over pc 1
    load(8'd0, 16'h002F);
    load(8'd1, 16'h5555);
    load(8'd2, 16'h2232);
    sb.push_back(16'h2232);
    go();
    cyc(1);
    chk("jmp_bubble", {31'h0, instr_valid}, 32'h0);
    chk("jmp_pc", {24'h0, pc}, 32'd2);
    cyc(1);
    chk("jmp_issue", {15'h0, instr_valid, instruction}, 32'h1_2232);
    wait_halt("jmp_halt");
    chk("jmp_sb", sb.size(), 32'd0);

    // Branch loop: taken, taken, not taken
    load(8'd0, 16'h1001);
    load(8'd1, 16'hF24E);
    load(8'd2, 16'h3003);
    load(8'd3, 16'h4004);
    prog_len = 8'd4;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(16'h1001);
      sb.push_back(16'hF24E);
    end
    sb.push_back(16'h3003);
    sb.push_back(16'h4004);
    go();
    for (int k = 0; k < 3; k++) begin
      wait_br(16'hF24E);
      chk("loop_pc_br", {24'h0, pc}, 32'd1);
      br_valid = 1'b1;
      br_taken = (k < 2);
      cyc(1);
      br_valid = 1'b0;
      chk("loop_pc_tgt", {24'h0, pc}, (k < 2) ? 32'd0 : 32'd2);
    end
    wait_halt("loop_halt");
    chk("loop_pc_end", {24'h0, pc}, 32'd4);
    chk("loop_sb", sb.size(), 32'd0);

    // Backpressure mid-stream
    load(8'd1, 16'h2002);
    sb.push_back(16'h1001);
    sb.push_back(16'h2002);
    sb.push_back(16'h3003);
    sb.push_back(16'h4004);
    go();
    cyc(2);
    chk("bp_first", {15'h0, instr_valid, instruction}, 32'h1_2002);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("bp_hold", {15'h0, instr_valid, instruction}, 32'h1_2002);
      chk("bp_pc", {24'h0, pc}, 32'd2);
    end
    instr_ready = 1'b1;
    wait_halt("bp_halt");
    chk("bp_sb", sb.size(), 32'd0);

    // Early br_valid is ignored until the branch is accepted
    load(8'd1, 16'h224E);
    sb.push_back(16'h1001);
    sb.push_back(16'h224E);
    sb.push_back(16'h4004);
    go();
    wait_br(16'h224E);
    instr_ready = 1'b0;
    br_valid    = 1'b1;
    br_taken    = 1'b1;
    cyc(2);
    chk("early_pc", {24'h0, pc}, 32'd1);
    chk("early_valid", {31'h0, instr_valid}, 32'h1);
    br_valid    = 1'b0;
    instr_ready = 1'b1;
    cyc(1);
    chk("early_acc_pc", {24'h0, pc}, 32'd1);
    chk("early_acc_valid", {31'h0, instr_valid}, 32'h0);
    br_valid = 1'b1;
    cyc(1);
    br_valid = 1'b0;
    chk("early_redirect", {24'h0, pc}, 32'd3);
    wait_halt("early_halt");
    chk("early_sb", sb.size(), 32'd0);

    // Write during FETCH is dropped; reset in BR_WAIT
    sb.push_back(16'h1001);
    sb.push_back(16'h224E);
    go();
    prog_we   = 1'b1;
    prog_addr = 8'd3;
    prog_data = 16'hDEAD;
    cyc(1);
    prog_we   = 1'b0;
    wait_br(16'h224E);
    instr_ready = 1'b0;
    cyc(1);
    reset = 1'b1;
    sb.delete();
    cyc(1);
    chk("mrst_instr", {16'h0, instruction}, 32'h0);
    chk("mrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mrst_pc", {24'h0, pc}, 32'h0);
    chk("mrst_halted", {31'h0, halted}, 32'h0);
    reset       = 1'b0;
    instr_ready = 1'b1;
    cyc(1);
    chk("mrst_idle_pc", {24'h0, pc}, 32'h0);
    sb.push_back(16'h1001);
    sb.push_back(16'h224E);
    sb.push_back(16'h4004);
    go();
    wait_br(16'h224E);
    br_valid = 1'b1;
    br_taken = 1'b1;
    cyc(1);
    br_valid = 1'b0;
    cyc(1);
    chk("we_ignored", {15'h0, instr_valid, instruction}, 32'h1_4004);
    wait_halt("rerun_halt");
    chk("rerun_sb", sb.size(), 32'd0);

    // Empty program halts without issuing
    prog_len = 8'd0;
    go();
    chk("empty_valid", {31'h0, instr_valid}, 32'h0);
    cyc(1);
    chk("empty_halt", {31'h0, halted}, 32'h1);
    chk("empty_sb", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
